dsp_mac_pipe: RTL and testbench

Parametrised, fully pipelined signed multiply-accumulate slice. It is the next generation of our DSP48A1-style slice and provides a pre-adder, multiplier, post-adder/accumulator and cascade output. New relative to the fixed slice: generic operand widths, a valid/ready stream handshake with backpressure, optional saturation with an overflow flag, and a fixed 3-cycle latency. It sits in datapaths as a streaming MAC; slices are chained via PCIN/PCOUT.

---
 rtl/dsp_mac_pkg.sv | 30 +++
 rtl/dsp_mac_postadd.sv | 56 +++++
 rtl/dsp_mac_pipe.sv | 150 +++++++++++++++
 tb/tb_dsp_mac_pipe.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_mac_pkg.sv
// Shared definitions for the pipelined MAC slice: OPMODE field positions, Z-mux encodings
// and the stage-2/3 control bundle.
package dsp_mac_pkg;

  localparam int unsigned OPMODE_W  = 5;
  localparam int unsigned PREADD_EN = 0;
  localparam int unsigned PRE_SUB   = 1;
  localparam int unsigned ZSEL_LO   = 2;
  localparam int unsigned ZSEL_HI   = 3;
  localparam int unsigned POST_SUB  = 4;

  typedef enum logic [1:0] {
    Z_ZERO = 2'b00,
    Z_C    = 2'b01,
    Z_P    = 2'b10,
    Z_PCIN = 2'b11
  } zsel_e;

  // Only the post-adder controls survive past the pre-adder stage.
  typedef struct packed {
    logic  post_sub;
    zsel_e zsel;
  } post_op_t;

  // Top three bits of a sign-extended sum disagree exactly when it left the signed range.
  function automatic logic sum_overflow(input logic [2:0] top);
    return !((top == 3'b000) || (top == 3'b111));
  endfunction

endpackage

// File: rtl/dsp_mac_postadd.sv
// Combinational post-adder: Z-source mux, add/subtract with carry-in, signed overflow
// detection, optional saturation and unsigned carry/borrow out.
module dsp_mac_postadd
  import dsp_mac_pkg::*;
#(
  parameter int unsigned PW       = 48,
  parameter bit          SATURATE = 1'b1
) (
  input  post_op_t        op_i,
  input  logic [PW-1:0]   ms_i,
  input  logic [PW-1:0]   c_i,
  input  logic [PW-1:0]   p_i,
  input  logic [PW-1:0]   pcin_i,
  input  logic            carry_i,
  output logic [PW-1:0]   p_o,
  output logic            ovf_o,
  output logic            carry_o
);

  logic [PW-1:0] z;
  logic [PW+1:0] zx, mx, cx, s;
  logic [PW:0]   u;
  logic          ovf;

  always_comb begin
    z = '0;
    unique case (op_i.zsel)
      Z_C:     z = c_i;
      Z_P:     z = p_i;
      Z_PCIN:  z = pcin_i;
      default: z = '0;
    endcase

    // Two guard bits keep the true signed sum representable.
    zx = {{2{z[PW-1]}}, z};
    mx = {{2{ms_i[PW-1]}}, ms_i};
    cx = {{(PW + 1){1'b0}}, carry_i};

    if (op_i.post_sub) begin
      s = zx - (mx + cx);
      u = {1'b0, z} - {1'b0, ms_i} - {{PW{1'b0}}, carry_i};
    end else begin
      s = zx + mx + cx;
      u = {1'b0, z} + {1'b0, ms_i} + {{PW{1'b0}}, carry_i};
    end

    ovf     = sum_overflow(s[PW+1:PW-1]);
    ovf_o   = ovf;
    carry_o = u[PW];
    p_o     = s[PW-1:0];
    if (SATURATE && ovf) begin
      p_o = s[PW+1] ? {1'b1, {(PW - 1){1'b0}}} : {1'b0, {(PW - 1){1'b1}}};
    end
  end

endmodule

// File: rtl/dsp_mac_pipe.sv
// Three-stage streaming signed MAC slice: pre-adder, multiplier, post-adder/accumulator,
// with a global valid/ready stall and PCIN/PCOUT cascade.
module dsp_mac_pipe
  import dsp_mac_pkg::*;
#(
  parameter int unsigned AW       = 18,
  parameter int unsigned BW       = 18,
  parameter int unsigned PW       = 48,
  parameter bit          SATURATE = 1'b1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [AW-1:0]       A,
  input  logic [BW-1:0]       B,
  input  logic [AW-1:0]       D,
  input  logic [PW-1:0]       C,
  input  logic [PW-1:0]       PCIN,
  input  logic                CARRYIN,
  input  logic [OPMODE_W-1:0] OPMODE,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PW-1:0]       P,
  output logic [PW-1:0]       PCOUT,
  output logic [AW+BW-1:0]    M,
  output logic                CARRYOUT,
  output logic                OVF
);

  localparam int unsigned MW = AW + BW;

  logic en;

  // Stage 1
  logic [AW-1:0]       a1_q, d1_q;
  logic [BW-1:0]       b1_q;
  logic [PW-1:0]       c1_q, pcin1_q;
  logic                cin1_q, v1_q;
  logic [OPMODE_W-1:0] op1_q;

  // Stage 2
  logic [MW-1:0] m2_q;
  logic [PW-1:0] c2_q, pcin2_q;
  logic          cin2_q, v2_q;
  post_op_t      op2_q;

  // Stage 3
  logic [PW-1:0] p_q;
  logic [MW-1:0] m3_q;
  logic          co_q, ovf_q, v3_q;

  logic signed [BW-1:0] d_ext, pb_d;
  logic signed [MW-1:0] pb_x, a_x, m2_d;
  post_op_t             op2_d;
  logic [PW-1:0]        ms, p_d;
  logic                 ovf_d, co_d;

  // Whole pipe advances together so bubbles keep their slots.
  assign en       = !v3_q || out_ready;
  assign in_ready = en;

  always_comb begin
    d_ext = BW'($signed(d1_q));
    pb_d  = $signed(b1_q);
    if (op1_q[PREADD_EN]) begin
      pb_d = op1_q[PRE_SUB] ? d_ext - $signed(b1_q) : d_ext + $signed(b1_q);
    end
    pb_x = MW'(pb_d);
    a_x  = MW'($signed(a1_q));
    m2_d = pb_x * a_x;

    op2_d.post_sub = op1_q[POST_SUB];
    op2_d.zsel     = zsel_e'(op1_q[ZSEL_HI:ZSEL_LO]);
  end

  assign ms = PW'($signed(m2_q));

  dsp_mac_postadd #(
    .PW       (PW),
    .SATURATE (SATURATE)
  ) u_postadd (
    .op_i    (op2_q),
    .ms_i    (ms),
    .c_i     (c2_q),
    .p_i     (p_q),
    .pcin_i  (pcin2_q),
    .carry_i (cin2_q),
    .p_o     (p_d),
    .ovf_o   (ovf_d),
    .carry_o (co_d)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a1_q    <= '0;
      d1_q    <= '0;
      b1_q    <= '0;
      c1_q    <= '0;
      pcin1_q <= '0;
      cin1_q  <= 1'b0;
      op1_q   <= '0;
      v1_q    <= 1'b0;
      m2_q    <= '0;
      c2_q    <= '0;
      pcin2_q <= '0;
      cin2_q  <= 1'b0;
      op2_q   <= '0;
      v2_q    <= 1'b0;
      p_q     <= '0;
      m3_q    <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      v3_q    <= 1'b0;
    end else if (en) begin
      a1_q    <= A;
      d1_q    <= D;
      b1_q    <= B;
      c1_q    <= C;
      pcin1_q <= PCIN;
      cin1_q  <= CARRYIN;
      op1_q   <= OPMODE;
      v1_q    <= in_valid;

      m2_q    <= m2_d;
      c2_q    <= c1_q;
      pcin2_q <= pcin1_q;
      cin2_q  <= cin1_q;
      op2_q   <= op2_d;
      v2_q    <= v1_q;

      v3_q <= v2_q;
      // Bubbles must not disturb the accumulator.
      if (v2_q) begin
        p_q   <= p_d;
        m3_q  <= m2_q;
        co_q  <= co_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = v3_q;
  assign P         = p_q;
  assign PCOUT     = p_q;
  assign M         = m3_q;
  assign CARRYOUT  = co_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Directed self-checking bench for dsp_mac_pipe (saturating and wrapping instances).
module tb_dsp_mac_pipe;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        in_valid, out_ready, CARRYIN;
  logic [17:0] A, B, D;
  logic [47:0] C, PCIN;
  logic [4:0]  OPMODE;

  logic        in_ready, out_valid, CARRYOUT, OVF;
  logic [47:0] P, PCOUT;
  logic [35:0] M;

  logic        w_in_ready, w_out_valid, w_CARRYOUT, w_OVF;
  logic [47:0] w_P, w_PCOUT;
  logic [35:0] w_M;

  int checks = 0;
  int errors = 0;

  logic [47:0] got_p[$];
  logic [35:0] got_m[$];

  always #5 CLK = ~CLK;

  dsp_mac_pipe #(.AW(18), .BW(18), .PW(48), .SATURATE(1'b1)) dut (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B), .D(D),
    .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN), .OPMODE(OPMODE), .out_valid(out_valid),
    .out_ready(out_ready), .P(P), .PCOUT(PCOUT), .M(M), .CARRYOUT(CARRYOUT), .OVF(OVF)
  );

  dsp_mac_pipe #(.AW(18), .BW(18), .PW(48), .SATURATE(1'b0)) dut_wrap (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(w_in_ready), .A(A), .B(B), .D(D),
    .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN), .OPMODE(OPMODE), .out_valid(w_out_valid),
    .out_ready(out_ready), .P(w_P), .PCOUT(w_PCOUT), .M(w_M), .CARRYOUT(w_CARRYOUT),
    .OVF(w_OVF)
  );

  // Record each result at the negedge before the edge that hands it off.
  always @(negedge CLK) begin
    if (RST_N && out_valid && out_ready) begin
      got_p.push_back(P);
      got_m.push_back(M);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present one sample and hold it until an edge actually accepts it.
  task automatic send(input logic [17:0] a, input logic [17:0] b, input logic [17:0] d,
                      input logic [47:0] c, input logic [47:0] pcin, input logic cin,
                      input logic [4:0] op);
    logic acc;
    A = a; B = b; D = d; C = c; PCIN = pcin; CARRYIN = cin; OPMODE = op;
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      acc = in_ready;
      tick();
      if (acc) break;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    int stale;
    RST_N = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; D = '0; C = '0; PCIN = '0; CARRYIN = 1'b0; OPMODE = '0;
    tick(); tick();
    checks++; if (P !== 48'd0) begin errors++; $display("FAIL reset_p: got %0h want 0", P); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (M !== 36'd0 || OVF !== 1'b0 || CARRYOUT !== 1'b0) begin
      errors++; $display("FAIL reset_flags: M=%0h OVF=%b CO=%b want 0", M, OVF, CARRYOUT);
    end
    RST_N = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end

    for (int i = 0; i < 3; i++) send(18'd1, 18'd1, 18'd0, 48'd7, 48'd0, 1'b0, 5'h04);
    checks++; if (out_valid !== 1'b1 || P !== 48'd8) begin
      errors++; $display("FAIL pre_reset_result: valid=%b P=%0d want 1/8", out_valid, P);
    end
    #2 RST_N = 1'b0;
    #1;
    checks++; if (P !== 48'd0) begin errors++; $display("FAIL async_reset_p: got %0h want 0", P); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b want 0", out_valid); end
    tick(); tick();
    RST_N = 1'b1;
    got_p.delete(); got_m.delete();
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL reset_stale: got %0d results want 0", stale); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    send(18'd2, 18'd5, 18'd3, 48'd4, 48'd0, 1'b1, 5'h05);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_lat1: got %b want 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_lat2: got %b want 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_lat3: got %b want 1", out_valid); end
    checks++; if (M !== 36'd16) begin errors++; $display("FAIL basic_m: got %0d want 16", M); end
    checks++; if (P !== 48'd21) begin errors++; $display("FAIL basic_p: got %0d want 21", P); end
    checks++; if (PCOUT !== 48'd21) begin errors++; $display("FAIL basic_pcout: got %0d want 21", PCOUT); end
    checks++; if (OVF !== 1'b0 || CARRYOUT !== 1'b0) begin
      errors++; $display("FAIL basic_flags: OVF=%b CO=%b want 0/0", OVF, CARRYOUT);
    end
    tick();
  endtask

  task automatic test_accumulate();
    logic [47:0] exp_p [4] = '{48'd12, 48'd24, 48'd36, 48'd48};
    got_p.delete(); got_m.delete();
    send(18'd3, 18'd4, 18'd0, 48'd0, 48'd0, 1'b0, 5'h00);
    for (int i = 0; i < 3; i++) send(18'd3, 18'd4, 18'd0, 48'd0, 48'd0, 1'b0, 5'h08);
    for (int k = 0; k < 20 && got_p.size() < 4; k++) tick();
    tick(); tick();
    checks++; if (got_p.size() != 4) begin errors++; $display("FAIL acc_count: got %0d want 4", got_p.size()); end
    for (int i = 0; i < 4 && i < got_p.size(); i++) begin
      checks++;
      if (got_p[i] !== exp_p[i]) begin
        errors++; $display("FAIL acc_p[%0d]: got %0d want %0d", i, got_p[i], exp_p[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [47:0] p_hold;
    got_p.delete(); got_m.delete();
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(18'(10 * (i + 1)), 18'd1, 18'd0, 48'd100, 48'd0, 1'b0, 5'h04);
      end
      begin
        tick(); tick(); tick();
        out_ready = 1'b0;
        p_hold = P;
        checks++; if (out_valid !== 1'b1 || p_hold !== 48'd110) begin
          errors++; $display("FAIL bp_stall_entry: valid=%b P=%0d want 1/110", out_valid, p_hold);
        end
        for (int i = 0; i < 5; i++) begin
          tick();
          checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
          checks++; if (P !== p_hold || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_hold[%0d]: P=%0d valid=%b want %0d/1", i, P, out_valid, p_hold);
          end
        end
        out_ready = 1'b1;
      end
    join
    for (int k = 0; k < 40 && got_p.size() < 6; k++) tick();
    for (int k = 0; k < 5; k++) tick();
    checks++; if (got_p.size() != 6) begin errors++; $display("FAIL bp_count: got %0d want 6", got_p.size()); end
    for (int i = 0; i < 6 && i < got_p.size(); i++) begin
      checks++;
      if (got_p[i] !== 48'(100 + 10 * (i + 1)) || got_m[i] !== 36'(10 * (i + 1))) begin
        errors++;
        $display("FAIL bp_order[%0d]: P=%0d M=%0d want %0d/%0d", i, got_p[i], got_m[i],
                 100 + 10 * (i + 1), 10 * (i + 1));
      end
    end
  endtask

  task automatic test_saturation();
    send(18'd1, 18'd1, 18'd0, 48'h7FFF_FFFF_FFFF, 48'd0, 1'b0, 5'h04);
    tick(); tick();
    checks++; if (out_valid !== 1'b1 || P !== 48'h7FFF_FFFF_FFFF || OVF !== 1'b1) begin
      errors++; $display("FAIL sat_pos: valid=%b P=%h OVF=%b want 1/7fffffffffff/1", out_valid, P, OVF);
    end
    checks++; if (w_out_valid !== 1'b1 || w_P !== 48'h8000_0000_0000 || w_OVF !== 1'b1) begin
      errors++; $display("FAIL wrap_pos: valid=%b P=%h OVF=%b want 1/800000000000/1", w_out_valid, w_P, w_OVF);
    end
    checks++; if (w_M !== 36'd1 || w_CARRYOUT !== 1'b0 || w_PCOUT !== 48'h8000_0000_0000 || w_in_ready !== 1'b1) begin
      errors++; $display("FAIL wrap_aux: M=%0h CO=%b PCOUT=%h rdy=%b", w_M, w_CARRYOUT, w_PCOUT, w_in_ready);
    end
    tick();
    send(18'd1, 18'd1, 18'd0, 48'h8000_0000_0000, 48'd0, 1'b0, 5'h14);
    tick(); tick();
    checks++; if (P !== 48'h8000_0000_0000 || OVF !== 1'b1 || CARRYOUT !== 1'b0) begin
      errors++; $display("FAIL sat_neg: P=%h OVF=%b CO=%b want 800000000000/1/0", P, OVF, CARRYOUT);
    end
    checks++; if (w_P !== 48'h7FFF_FFFF_FFFF || w_OVF !== 1'b1) begin
      errors++; $display("FAIL wrap_neg: P=%h OVF=%b want 7fffffffffff/1", w_P, w_OVF);
    end
    tick();
  endtask

  task automatic test_subtract();
    send(18'd5, 18'd9, 18'd4, 48'd8, 48'd0, 1'b1, 5'h17);
    tick(); tick();
    checks++; if (M !== 36'hF_FFFF_FFE7) begin errors++; $display("FAIL sub_m: got %h want fffffffe7", M); end
    checks++; if (P !== 48'd32) begin errors++; $display("FAIL sub_p: got %0d want 32", P); end
    checks++; if (CARRYOUT !== 1'b1 || OVF !== 1'b0) begin
      errors++; $display("FAIL sub_flags: CO=%b OVF=%b want 1/0", CARRYOUT, OVF);
    end
    tick();
  endtask

  task automatic test_cascade();
    send(18'd0, 18'd0, 18'd0, 48'd0, 48'h0123_4567_89AB, 1'b1, 5'h0C);
    send(18'd1, 18'd2, 18'd0, 48'd0, 48'd0, 1'b0, 5'h08);
    tick();
    checks++; if (P !== 48'h0123_4567_89AC || PCOUT !== 48'h0123_4567_89AC) begin
      errors++; $display("FAIL cascade_p: P=%h PCOUT=%h want 0123456789ac", P, PCOUT);
    end
    tick();
    checks++; if (P !== 48'h0123_4567_89AE) begin
      errors++; $display("FAIL cascade_acc: got %h want 0123456789ae", P);
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_accumulate();
    test_backpressure();
    test_saturation();
    test_subtract();
    test_cascade();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
